m_prog_loader: RTL
==================

Name: m_prog_loader

Overview:
- Serial program loader that sits directly upstream of the processor's instruction memory.
- Receives a program image over a UART line, assembles 32-bit little-endian words and drives the write port of the instruction `m_memory` (address/we/din).
- Holds the processor in reset while loading and releases it once the last word is written.
- Replaces the fixed `program.txt` preload on the FPGA build; simulation may still preload.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per UART bit (8N1); must be >= 4.
- ADDR_W, 11, word-address width of instruction memory.
- DEPTH, 2048, maximum number of words accepted.

Ports:
- w_clk  input  1  system clock (same clock as the processor).
- w_rst_n  input  1  reset, asynchronous, active-low.
- w_rxd  input  1  UART receive line, idle high, asynchronous to w_clk.
- r_we  output  1  one-cycle write strobe to the instruction memory.
- r_addr  output  ADDR_W  word address of the write.
- r_data  output  32  word to write.
- r_busy  output  1  load in progress, from the first header byte until done.
- r_done  output  1  high after a successful load; cleared by the next header byte.
- r_err  output  1  sticky error flag; cleared only by reset or the next successful load.
- r_proc_rst_n  output  1  processor reset, active-low; low at reset and while r_busy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: r_we=0, r_addr=0, r_data=0, r_busy=0, r_done=0, r_err=0, r_proc_rst_n=0. All internal state is reset, including the synchronizer flops (to 1).
- UART receiver (8N1):
  - w_rxd passes through a 2-flop synchronizer.
  - A start is a falling edge (1 to 0) seen at the synchronizer output while the receiver is idle.
  - The start bit is re-sampled at CLKS_PER_BIT/2. If it reads 1, it is a glitch and the receiver returns to idle with no byte and no error.
  - 8 data bits, LSB first, are sampled at mid-bit, every CLKS_PER_BIT cycles.
  - Stop bit sampled at mid-bit: if 1, emit byte valid for exactly one cycle; if 0, framing error: set r_err, no byte, back to idle.
  - Idle is entered right after the stop-bit sample, so back-to-back frames are accepted.
- Protocol: 2-byte word count N (little-endian, N[7:0] first), then N words of 4 bytes each, little-endian (byte0 = bits 7:0).
- Loader FSM, states LEN0 -> LEN1 -> DATA -> DONE:
  - LEN0: on a byte, latch N[7:0]; set r_busy=1, r_proc_rst_n=0, r_done=0; go to LEN1.
  - LEN1: on a byte, latch N[15:8]. Then:
    - N=0: go to DONE next cycle, with r_done=1, r_busy=0, r_proc_rst_n=1.
    - N>DEPTH: set r_err, r_busy=0, go to LEN0. r_proc_rst_n stays 0 and no write is issued.
    - Otherwise: clear word index and byte index, go to DATA.
  - DATA: shift bytes in. On the 4th byte, in the next cycle: r_we=1 (one cycle), r_addr=word index, r_data=assembled word; then the word index increments.
    - After the write of word N-1, the following cycle: r_done=1, r_busy=0, r_proc_rst_n=1, r_err=0; go to DONE.
  - DONE: any new byte is treated as LEN0 (reload). r_proc_rst_n drops the cycle after that byte's valid.
- Word index is ADDR_W+1 bits wide, so N=DEPTH completes without wrap; the last address is DEPTH-1.
- A framing error during DATA sets r_err, discards the partial word and aborts to LEN0 with r_busy=0 and r_proc_rst_n held 0. Words already written stay in memory.
- r_we is never high for more than one cycle, and is never high while r_proc_rst_n=1.
- Asserting w_rst_n mid-load aborts immediately; all outputs return to their reset values. No partial write is issued.

Decomposition:
- Shared package: the state encodings (LEN0/LEN1/DATA/DONE; the RX states IDLE/START/BITS/STOP), the NOP constant and the default CLKS_PER_BIT.
- Sub-module: m_uart_rx (synchronizer, baud counter, bit shifter). Outputs are an 8-bit byte, one-cycle byte valid, and a one-cycle framing-error pulse.

Test Plan (CLKS_PER_BIT=4):
- Send N=2 (0x02,0x00), then 0x20,0x00,0x00,0x00 and 0x08,0x00,0x21,0x20 -> writes addr0=0x00000020 and addr1=0x20210008, each a one-cycle r_we; r_done=1 and r_proc_rst_n=1 one cycle after the second write.
- Send N=0 -> no r_we; r_done=1 and r_proc_rst_n=1 two cycles after the second byte valid.
- Send N=0x0801 (2049) -> r_err=1, no r_we, r_proc_rst_n stays 0. Then a valid N=1 load -> r_done=1 and r_err=0.
- Drive the stop bit low on the 3rd data byte of N=1 -> r_err=1, no write, FSM back at LEN0. A later good load succeeds.
- Pull w_rxd low for 1 cycle -> no byte, no error. Assert w_rst_n low mid-DATA -> all outputs at reset values, with no spurious r_we.
- After a completed load, send a new header byte -> r_proc_rst_n=0, r_done=0, r_busy=1 on the cycle after the byte valid.

Source files
------------

// File: rtl/m_prog_loader_pkg.sv
// rtl/m_prog_loader_pkg.sv - shared encodings and constants for the serial program loader
package m_prog_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 100;

  // RISC-V addi x0,x0,0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    LD_LEN0 = 2'd0,
    LD_LEN1 = 2'd1,
    LD_DATA = 2'd2,
    LD_DONE = 2'd3
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/m_prog_loader_if.sv
// rtl/m_prog_loader_if.sv - received-byte stream from the UART receiver to the loader FSM
interface m_prog_loader_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       ferr;

  modport master (output tdata, output tvalid, output ferr);
  modport slave  (input  tdata, input  tvalid, input  ferr);
endinterface

// File: rtl/m_prog_loader_uart_rx.sv
// rtl/m_prog_loader_uart_rx.sv - 8N1 UART receiver with start-glitch rejection and framing-error pulse
module m_uart_rx
  import m_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_rxd,
  m_prog_loader_if.master o_rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        r_state;
  rx_state_t        w_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bidx;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_ferr;

  logic w_fall;
  logic w_half;
  logic w_tick;
  logic w_cnt_clr;
  logic w_sample;
  logic w_valid;
  logic w_ferr;

  // r_prev tracks the previous synchronized level so a line already low on
  // return to idle (after a framing error) does not fake a start edge
  assign w_fall = r_prev & ~r_sync2;
  assign w_half = (r_cnt == LP_HALF);
  assign w_tick = (r_cnt == LP_FULL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RX_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half) w_next = r_sync2 ? RX_IDLE : RX_BITS;
      RX_BITS:  if (w_tick && (r_bidx == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr = 1'b0;
    w_sample  = 1'b0;
    w_valid   = 1'b0;
    w_ferr    = 1'b0;
    unique case (r_state)
      RX_IDLE:  w_cnt_clr = 1'b1;
      RX_START: w_cnt_clr = w_half;
      RX_BITS: begin
        w_cnt_clr = w_tick;
        w_sample  = w_tick;
      end
      RX_STOP: begin
        w_cnt_clr = w_tick;
        w_valid   = w_tick & r_sync2;
        w_ferr    = w_tick & ~r_sync2;
      end
      default:  w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      if (r_state == RX_IDLE) r_bidx <= '0;
      else if (w_sample)      r_bidx <= r_bidx + 1'b1;
      if (w_sample) r_shift <= {r_sync2, r_shift[7:1]};
    end
  end

  assign o_rx.tdata  = r_shift;
  assign o_rx.tvalid = r_valid;
  assign o_rx.ferr   = r_ferr;

endmodule

// File: rtl/m_prog_loader.sv
// rtl/m_prog_loader.sv - UART program loader driving the instruction-memory write port and processor reset
module m_prog_loader
  import m_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = 11,
  parameter int DEPTH        = 2048
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_data,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err,
  output logic              r_proc_rst_n
);

  localparam int IDX_W = ADDR_W + 1;

  m_prog_loader_if u_rx_if ();

  m_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk  (w_clk),
    .i_rst_n(w_rst_n),
    .i_rxd  (w_rxd),
    .o_rx   (u_rx_if.master)
  );

  ld_state_t        r_state;
  ld_state_t        w_next;
  logic [15:0]      r_len;
  logic             r_len_pend;
  logic [IDX_W-1:0] r_widx;
  logic [1:0]       r_bidx;
  logic [31:0]      r_word;

  logic       w_byte;
  logic       w_ferr;
  logic [7:0] w_rx_byte;
  logic       w_len_zero;
  logic       w_len_big;
  logic       w_last;

  logic w_start;
  logic w_len_hi;
  logic w_eval;
  logic w_abort;
  logic w_shift;
  logic w_write;
  logic w_finish;
  logic w_too_big;

  assign w_byte     = u_rx_if.tvalid;
  assign w_ferr     = u_rx_if.ferr;
  assign w_rx_byte  = u_rx_if.tdata;
  assign w_len_zero = (r_len == 16'd0);
  assign w_len_big  = (32'(r_len) > DEPTH);
  // r_widx has already advanced past the word currently on the write port
  assign w_last     = (32'(r_widx) == 32'(r_len));

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= LD_LEN0;
    else          r_state <= w_next;
  end

  // The length is evaluated one cycle after its high byte, once r_len is complete
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LD_LEN0, LD_DONE: if (w_byte) w_next = LD_LEN1;
      LD_LEN1: begin
        if (w_ferr)               w_next = LD_LEN0;
        else if (r_len_pend) begin
          if (w_len_zero)         w_next = LD_DONE;
          else if (w_len_big)     w_next = LD_LEN0;
          else                    w_next = LD_DATA;
        end
      end
      LD_DATA: begin
        if (w_ferr)               w_next = LD_LEN0;
        else if (r_we && w_last)  w_next = LD_DONE;
      end
      default:                    w_next = LD_LEN0;
    endcase
  end

  always_comb begin
    w_start   = 1'b0;
    w_len_hi  = 1'b0;
    w_eval    = 1'b0;
    w_abort   = 1'b0;
    w_shift   = 1'b0;
    w_write   = 1'b0;
    w_finish  = 1'b0;
    w_too_big = 1'b0;
    unique case (r_state)
      LD_LEN0, LD_DONE: w_start = w_byte;
      LD_LEN1: begin
        w_abort   = w_ferr;
        w_len_hi  = w_byte & ~r_len_pend;
        w_eval    = r_len_pend & ~w_ferr;
        w_finish  = w_eval & w_len_zero;
        w_too_big = w_eval & ~w_len_zero & w_len_big;
      end
      LD_DATA: begin
        w_abort  = w_ferr;
        w_shift  = w_byte;
        w_write  = w_byte & (r_bidx == 2'd3);
        w_finish = r_we & w_last & ~w_ferr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_proc_rst_n <= 1'b0;
      r_len        <= '0;
      r_len_pend   <= 1'b0;
      r_widx       <= '0;
      r_bidx       <= '0;
      r_word       <= '0;
    end else begin
      r_we <= w_write;
      if (w_start) begin
        r_len[7:0]   <= w_rx_byte;
        r_len_pend   <= 1'b0;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_proc_rst_n <= 1'b0;
      end
      if (w_len_hi) begin
        r_len[15:8] <= w_rx_byte;
        r_len_pend  <= 1'b1;
      end
      if (w_eval) begin
        r_len_pend <= 1'b0;
        r_widx     <= '0;
        r_bidx     <= '0;
      end
      if (w_shift) begin
        r_word <= {w_rx_byte, r_word[31:8]};
        r_bidx <= r_bidx + 1'b1;
      end
      if (w_write) begin
        r_data <= {w_rx_byte, r_word[31:8]};
        r_addr <= r_widx[ADDR_W-1:0];
        r_widx <= r_widx + 1'b1;
      end
      if (w_finish) begin
        r_done       <= 1'b1;
        r_busy       <= 1'b0;
        r_proc_rst_n <= 1'b1;
        r_err        <= 1'b0;
      end
      if (w_abort || w_too_big) begin
        r_busy     <= 1'b0;
        r_len_pend <= 1'b0;
      end
      if (w_ferr || w_too_big) r_err <= 1'b1;
    end
  end

endmodule
